seq_adder_nbit: RTL
===================

Name: seq_adder_nbit

Overview:
- Parametrised, multi-cycle adder/subtractor that processes CHUNK bits per clock, ripple-style, across WIDTH-bit operands.
- Successor to the combinational 32-bit adder: adds width/chunk parameters, a subtract mode, a signed-overflow flag and a start/busy/done handshake.
- Area-lean arithmetic unit inside the ALU datapath; trades latency for a narrow CHUNK-bit adder.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CHUNK, 8, bits added per cycle; WIDTH must be an integer multiple of CHUNK (elaboration error otherwise); N = WIDTH/CHUNK.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a+b+cin; 1 = a-b-cin (cin acts as borrow-in).
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- cin  input  1  carry-in / borrow-in; latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result.
- cout  output  1  raw carry out of MSB (sub: 1 = no borrow).
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- One clock; reset is synchronous and active-high (rst sampled on rising clk).
- Reset: state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, internal regs cleared.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE, start=1 at edge E0:
  - latch A=a, B'=sub ? ~b : b, carry=sub ? ~cin : cin;
  - chunk index=0; go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, edges E1..EN:
  - edge Ek adds chunk k-1 (bits [k*CHUNK-1:(k-1)*CHUNK]) of A and B' plus carry;
  - writes the result into the internal accumulator and updates carry.
  - On the top chunk, carry into the MSB is also captured.
- At EN:
  - sum <= accumulator incl. top chunk;
  - cout <= final carry;
  - overflow <= carry_into_MSB XOR final carry;
  - go to DONE.
- DONE: done=1 for exactly one cycle (decoded from state); next edge goes to IDLE unconditionally.
- busy=1 only in RUN; done and busy are never high together.
- Latency: done is high in the cycle following EN, i.e. N cycles after the start-sampling edge (N=4 at defaults). Next start is accepted no earlier than the IDLE cycle after done, so throughput is one op per N+2 cycles.
- sum/cout/overflow update only at EN and hold their values until the next completion or reset. No partial results are visible.
- start while busy or in DONE: ignored, not queued. Operand changes after E0 have no effect.
- rst during RUN/DONE:
  - abort at that edge; outputs and state take reset values;
  - no done pulse for the aborted op.
- rst and start high at the same edge: reset wins.
- CHUNK=WIDTH (N=1): single RUN cycle; same handshake.
- All arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH=32/CHUNK=8: a=0x000000F0, b=0x00000001, cin=0, sub=0, start pulse -> done exactly 4 cycles after start edge; sum=0x000000F1, cout=0, overflow=0; busy high 4 cycles.
- a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, overflow=0 (carry ripples through all chunks).
- a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cout=0, overflow=1; separately a=0x80000000, b=0x80000000 -> sum=0, cout=1, overflow=1.
- sub=1, a=5, b=7, cin=0 -> sum=0xFFFFFFFE, cout=0, overflow=0; sub=1, a=7, b=5, cin=1 -> sum=0x00000001, cout=1.
- Start pulsed again with new operands while busy -> ignored; the original result is delivered; one done pulse only.
- rst asserted for 1 cycle at the 2nd RUN cycle -> next cycle all outputs 0, state IDLE, no done; a fresh op afterwards completes correctly.
- Re-run the carry and overflow cases with WIDTH=16/CHUNK=4 and CHUNK=WIDTH=16 -> correct 16-bit results; latency 4 and 1 respectively.

Source files
------------

// File: rtl/seq_adder_nbit.sv
// seq_adder_nbit: multi-cycle ripple adder/subtractor, CHUNK bits per clock.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           operation request, accepted only while idle
//   sub             0: a + b + cin, 1: a - b - cin (cin is borrow-in)
//   a, b, cin       operands, captured when start is accepted
//   busy            high while chunks are being added
//   done            one-cycle pulse, result outputs valid
//   sum             result, updated only when an operation completes
//   cout            carry out of MSB (subtract: 1 means no borrow)
//   overflow        signed two's-complement overflow of the completed op
module seq_adder_nbit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("seq_adder_nbit: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;     // already inverted for subtract
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    int unsigned      base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_res;
    logic             msb_cin;

    // Next-state, chunk adder and result capture
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        base      = 32'(idx_q) * CHUNK;
        a_chunk   = a_q[base +: CHUNK];
        b_chunk   = b_q[base +: CHUNK];
        chunk_res = (CHUNK+1)'(a_chunk) + (CHUNK+1)'(b_chunk) + (CHUNK+1)'(carry_q);
        // Carry into the MSB recovered from the MSB's own sum bit
        msb_cin   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_res[CHUNK-1];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d[base +: CHUNK] = chunk_res[CHUNK-1:0];
                carry_d = chunk_res[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    sum_d   = acc_d;
                    cout_d  = chunk_res[CHUNK];
                    ovf_d   = msb_cin ^ chunk_res[CHUNK];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
